cke_sched: RTL and testbench
============================

Name: cke_sched

Overview:
Multi-channel clock-enable scheduler. It owns NCH independent clock-enable channels, each with its own divide ratio and high-phase length. Software/CPU-side logic programs the channels through a single valid/ready config port. Reconfiguration takes effect only at a channel's period boundary, so consumers such as UART, timers and display refresh never see a truncated or runt enable.

Parameters:
NCH, 4, number of clock-enable channels (1..16)
W, 26, divider/high-phase register width
DEF_DIV, 50000000, reset divide ratio of every channel (must fit in W bits)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  config request valid
cfg_ready  out  1  config slot free
cfg_ch  in  $clog2(NCH) (min 1)  target channel
cfg_div  in  W  period in clk cycles
cfg_high  in  W  cycles per period with cke high
cfg_en  in  1  channel enable
cke  out  NCH  per-channel clock enable
tick  out  NCH  one-cycle pulse at period start
busy  out  1  a config is pending (equals !cfg_ready)

Behaviour:
- Reset (synchronous, rst=1 at an edge) sets, for every channel:
  - cnt=0, div=DEF_DIV, high=DEF_DIV>>1, en=0
  - cke=0, tick=0
  - cfg_ready=1, pending slot empty
- Reset has priority over everything, including an in-flight accept. A pending config is discarded.
- Per channel, while en=1:
  - cnt counts 0..div-1 and wraps to 0.
  - cke and tick are registered and always consistent with cnt_q:
    - cke = en && (cnt < high)
    - tick = en && (cnt == 0)
- Width/edge rules:
  - cfg_div=0 is stored as 1. With div=1, tick is high every cycle.
  - high=0: cke constantly 0; tick still pulses.
  - high>=div: cke constantly 1 while enabled.
  - All compares are unsigned W-bit; no overflow is possible.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready at an edge.
  - The request is latched into a single shared pending slot; cfg_ready drops the following cycle.
  - cfg_valid is not required to hold; fields are sampled only at transfer.
- Apply rules, evaluated every cycle while pending:
  - Target channel disabled (en_q=0): apply at the next edge.
  - Request with cfg_en=0: apply at the next edge (immediate stop, no waiting for boundary).
  - Otherwise: apply at the edge where the target's cnt==div-1, i.e. the old period completes.
- On apply:
  - div/high/en are loaded and cnt is set to 0.
  - cke/tick are updated at that same edge to match cnt=0 under the new settings.
  - The slot frees, so cfg_ready=1 in the next cycle.
  - Earliest next accept is that same cycle.
- Timing: accept at edge E on a disabled channel → apply at edge E+1 → first tick and cke visible in cycle after E+1.
- Disabled channel: cnt held at 0, cke=0, tick=0.
- Other channels are never disturbed by a config to a different channel.
- State per slot: EMPTY → (accept) PENDING → (apply condition) EMPTY. There is no other state.

Optional Feature:
CKE_PHASE_SYNC_EN
- Defined:
  - An enabling apply on channel k>0 whose channel was disabled does not use the next edge. It waits for the edge where channel 0 has cnt==div0-1.
  - The new channel's first tick therefore coincides with channel 0's tick.
  - If channel 0 is disabled, it applies at the next edge as normal.
  - Reconfiguring an already-enabled channel is unchanged.
- Undefined: no alignment; rules exactly as in Behaviour.

Decomposition:
- Package cke_sched_pkg holds:
  - a cfg_t struct (ch, div, high, en)
  - the slot state enum (SLOT_EMPTY, SLOT_PENDING)
  - a function normalising div (0→1)
- One sub-module, cke_chan, instantiated NCH times. It contains cnt/div/high/en registers, the registered cke/tick, and apply/at_last outputs.
- The top level contains the handshake, pending slot and apply-select logic.

Test Plan:
1. Reset, then program ch0 div=4 high=2 en=1 → cfg_ready low 1 cycle; cke0 pattern 1,1,0,0 repeating; tick0 every 4 cycles, first one 2 cycles after accept edge.
2. With ch0 running at div=4, mid-period program div=6 high=3 → old period finishes (4 cycles total), then cke0 1,1,1,0,0,0; cfg_ready stays low until the boundary; a second cfg_valid held high is stalled, then accepted.
3. Edge configs:
   - high=0 → cke constant 0, tick every div cycles
   - high=7, div=5 → cke constant 1
   - div=0 → tick every cycle
4. Enabled ch1 div=10 at cnt=3 receives en=0 → cke1=0 and tick1=0 from the next cycle; ch0 pattern is unaffected throughout.
5. Assert rst for one cycle while a config is pending and channels are running → all cke/tick 0, cfg_ready=1, all en=0; after release, the channels stay idle.
6. With CKE_PHASE_SYNC_EN defined: ch0 div=8, then enable ch2 div=4 mid ch0 period → the first tick2 coincides with the next tick0. Without the macro, the first tick2 appears 2 cycles after accept.

Source files
------------

// File: rtl/cke_sched_pkg.sv
// Shared types for the clock-enable scheduler: config payload, slot state, div normalisation.
package cke_sched_pkg;

  localparam int unsigned MAX_W    = 32;
  localparam int unsigned MAX_CH_W = 4;

  typedef enum logic {
    SLOT_EMPTY   = 1'b0,
    SLOT_PENDING = 1'b1
  } slot_e;

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic [MAX_W-1:0]    div;
    logic [MAX_W-1:0]    high;
    logic                en;
  } cfg_t;

  // A zero period is meaningless; treat it as a one-cycle period.
  function automatic logic [MAX_W-1:0] norm_div(input logic [MAX_W-1:0] d);
    return (d == '0) ? MAX_W'(1) : d;
  endfunction

endpackage

// File: rtl/cke_chan.sv
// One clock-enable channel: period counter, settings registers and registered cke/tick.
module cke_chan #(
  parameter int unsigned W       = 26,
  parameter int unsigned DEF_DIV = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         apply,
  input  logic [W-1:0] new_div,
  input  logic [W-1:0] new_high,
  input  logic         new_en,
  output logic         cke,
  output logic         tick,
  output logic         en,
  output logic         at_last_c
);

  logic [W-1:0] cnt_q, div_q, high_q;
  logic [W-1:0] cnt_n, div_n, high_n;
  logic         en_n;

  assign at_last_c = (cnt_q == div_q - W'(1));

  // An apply restarts the period under the new settings.
  always_comb begin
    cnt_n  = '0;
    div_n  = div_q;
    high_n = high_q;
    en_n   = en;
    if (apply) begin
      div_n  = new_div;
      high_n = new_high;
      en_n   = new_en;
    end else if (en && !at_last_c) begin
      cnt_n = cnt_q + W'(1);
    end
  end

  // cke/tick are computed from the next count so they always match cnt_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= W'(DEF_DIV);
      high_q <= W'(DEF_DIV >> 1);
      en     <= 1'b0;
      cke    <= 1'b0;
      tick   <= 1'b0;
    end else begin
      cnt_q  <= cnt_n;
      div_q  <= div_n;
      high_q <= high_n;
      en     <= en_n;
      cke    <= en_n && (cnt_n < high_n);
      tick   <= en_n && (cnt_n == '0);
    end
  end

endmodule

// File: rtl/cke_sched.sv
// Multi-channel clock-enable scheduler with a single pending config slot.
// Optional CKE_PHASE_SYNC_EN aligns newly enabled channels to channel 0's period start.
module cke_sched
  import cke_sched_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned W       = 26,
  parameter int unsigned DEF_DIV = 50000000,
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_div,
  input  logic [W-1:0]    cfg_high,
  input  logic            cfg_en,
  output logic [NCH-1:0]  cke,
  output logic [NCH-1:0]  tick,
  output logic            busy
);

  slot_e          state_q, state_n;
  cfg_t           slot_q, slot_n;
  logic [NCH-1:0] en_vec, last_vec, apply_c;
  logic           go_c, tgt_en, tgt_last;
  logic           unused_slot;

  // Payload bits above W are always zero.
  assign unused_slot = ^slot_q;

  // Decide whether the pending request may take effect at the coming edge.
  always_comb begin
    tgt_en   = 1'b0;
    tgt_last = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (slot_q.ch == MAX_CH_W'(k)) begin
        tgt_en   = en_vec[k];
        tgt_last = last_vec[k];
      end
    end
    go_c = !tgt_en || !slot_q.en || tgt_last;
`ifdef CKE_PHASE_SYNC_EN
    if (!tgt_en && slot_q.en && (slot_q.ch != '0) && en_vec[0]) begin
      go_c = last_vec[0];
    end
`endif
  end

  always_comb begin
    state_n = state_q;
    slot_n  = slot_q;
    apply_c = '0;
    case (state_q)
      SLOT_EMPTY: begin
        if (cfg_valid) begin
          state_n     = SLOT_PENDING;
          slot_n.ch   = MAX_CH_W'(cfg_ch);
          slot_n.div  = norm_div(MAX_W'(cfg_div));
          slot_n.high = MAX_W'(cfg_high);
          slot_n.en   = cfg_en;
        end
      end
      SLOT_PENDING: begin
        if (go_c) begin
          state_n = SLOT_EMPTY;
          for (int unsigned k = 0; k < NCH; k++) begin
            apply_c[k] = (slot_q.ch == MAX_CH_W'(k));
          end
        end
      end
      default: state_n = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SLOT_EMPTY;
      slot_q    <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      slot_q    <= slot_n;
      cfg_ready <= (state_n == SLOT_EMPTY);
      busy      <= (state_n == SLOT_PENDING);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    cke_chan #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .apply     (apply_c[k]),
      .new_div   (W'(slot_q.div)),
      .new_high  (W'(slot_q.high)),
      .new_en    (slot_q.en),
      .cke       (cke[k]),
      .tick      (tick[k]),
      .en        (en_vec[k]),
      .at_last_c (last_vec[k])
    );
  end

endmodule

// File: tb/tb_cke_sched.sv
// Bench for cke_sched: directed scenarios with literal expectations plus a randomized run against a behavioural model.
module tb_cke_sched;

  localparam int unsigned NCH     = 4;
  localparam int unsigned W       = 26;
  localparam int unsigned DEF_DIV = 50000000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [W-1:0]   cfg_div = '0;
  logic [W-1:0]   cfg_high = '0;
  logic           cfg_en = 1'b0;
  logic [NCH-1:0] cke, tick;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  cke_sched #(.NCH(NCH), .W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_en(cfg_en),
    .cke(cke), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: per channel the position inside the current period, plus the one request slot.
  bit     m_en[NCH];
  longint m_div[NCH], m_high[NCH], m_ph[NCH];
  bit     m_pend, m_ren, m_acc;
  int     m_ch;
  longint m_rdiv, m_rhigh;
  bit     chk_on = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit go = 1'b0;
    bit app[NCH];
    m_acc = 1'b0;
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        m_en[k] = 1'b0; m_div[k] = DEF_DIV; m_high[k] = DEF_DIV / 2; m_ph[k] = 0;
      end
      m_pend = 1'b0;
      return;
    end
    for (int k = 0; k < NCH; k++) app[k] = 1'b0;
    if (m_pend) begin
      go = !m_en[m_ch] || !m_ren || (m_ph[m_ch] == m_div[m_ch] - 1);
`ifdef CKE_PHASE_SYNC_EN
      if (!m_en[m_ch] && m_ren && m_ch != 0 && m_en[0]) go = (m_ph[0] == m_div[0] - 1);
`endif
      if (go) app[m_ch] = 1'b1;
    end
    for (int k = 0; k < NCH; k++) begin
      if (app[k]) begin
        m_div[k] = m_rdiv; m_high[k] = m_rhigh; m_en[k] = m_ren; m_ph[k] = 0;
      end else if (m_en[k]) m_ph[k] = (m_ph[k] + 1) % m_div[k];
      else m_ph[k] = 0;
    end
    if (m_pend) begin
      if (go) m_pend = 1'b0;
    end else if (cfg_valid) begin
      m_pend = 1'b1; m_acc = 1'b1; m_ch = int'(cfg_ch);
      m_rdiv = (cfg_div == '0) ? 1 : longint'(cfg_div);
      m_rhigh = longint'(cfg_high); m_ren = cfg_en;
    end
  endtask

  // Every cycle after reset, outputs must equal what the model derives from period position.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [NCH-1:0] ec, et;
      for (int k = 0; k < NCH; k++) begin
        ec[k] = m_en[k] && (m_ph[k] < m_high[k]);
        et[k] = m_en[k] && (m_ph[k] == 0);
      end
      chk("cke", longint'(cke), longint'(ec));
      chk("tick", longint'(tick), longint'(et));
      chk("cfg_ready", longint'(cfg_ready), longint'(!m_pend));
      chk("busy", longint'(busy), longint'(m_pend));
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (m_acc) cfg_valid = 1'b0;
  endtask

  task automatic send(input int ch, input int div, input int high, input bit en);
    cfg_ch = 2'(ch); cfg_div = W'(div); cfg_high = W'(high); cfg_en = en;
    cfg_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_acc) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: ch %0d not accepted within 100 cycles", ch);
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] pc, pt;
    int cnt;
    // Reset
    step(); step();
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_cke", longint'(cke), 0);
    chk("rst_tick", longint'(tick), 0);
    chk("rst_ready", longint'(cfg_ready), 1);
    chk("rst_busy", longint'(busy), 0);

    // 1: ch0 div4 high2
    send(0, 4, 2, 1'b1);
    chk("t1_ready_low", longint'(cfg_ready), 0);
    chk("t1_busy", longint'(busy), 1);
    step();
    chk("t1_first_tick", longint'(tick[0]), 1);
    chk("t1_ready_back", longint'(cfg_ready), 1);
    for (int i = 0; i < 8; i++) begin
      pc[7-i] = cke[0]; pt[7-i] = tick[0];
      step();
    end
    chk("t1_cke_pattern", longint'(pc), 8'hCC);
    chk("t1_tick_pattern", longint'(pt), 8'h88);

    // 2: mid-period reconfigure, second request stalled behind it
    step();
    send(0, 6, 3, 1'b1);
    cfg_ch = 2'd1; cfg_div = W'(10); cfg_high = W'(5); cfg_en = 1'b1; cfg_valid = 1'b1;
    for (int i = 0; i < 10 && !tick[0]; i++) begin
      chk("t2_ready_low", longint'(cfg_ready), 0);
      step();
    end
    chk("t2_boundary_tick", longint'(tick[0]), 1);
    chk("t2_ready_after_apply", longint'(cfg_ready), 1);
    for (int i = 0; i < 6; i++) begin
      pc[5-i] = cke[0];
      step();
    end
    chk("t2_cke_pattern", longint'(pc[5:0]), 6'b111000);
    chk("t2_second_done", longint'(cfg_valid), 0);

    // 3: edge configurations
    send(2, 5, 0, 1'b1);
    step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_high0_cke", longint'(cke[2]), 0);
      cnt += int'(tick[2]);
      step();
    end
    chk("t3_high0_ticks", cnt, 2);
    send(2, 5, 7, 1'b1);
    for (int i = 0; i < 10 && !cfg_ready; i++) step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_high_ge_div_cke", longint'(cke[2]), 1);
      cnt += int'(tick[2]);
      step();
    end
    chk("t3_high_ge_div_ticks", cnt, 2);
    send(3, 0, 0, 1'b1);
    step();
    for (int i = 0; i < 6; i++) begin
      chk("t3_div0_tick", longint'(tick[3]), 1);
      step();
    end

    // 4: disable ch1 at cnt=3
    for (int i = 0; i < 20 && m_ph[1] != 3; i++) step();
    send(1, 10, 5, 1'b0);
    step();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      chk("t4_cke1_off", longint'(cke[1]), 0);
      chk("t4_tick1_off", longint'(tick[1]), 0);
      cnt += int'(tick[0]);
      step();
    end
    chk("t4_ch0_ticks", cnt, 2);

    // 5: reset while a config is pending
    send(0, 3, 1, 1'b1);
    chk("t5_pending", longint'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_ready", longint'(cfg_ready), 1);
    for (int i = 0; i < 20; i++) begin
      chk("t5_idle_cke", longint'(cke), 0);
      chk("t5_idle_tick", longint'(tick), 0);
      step();
    end

    // 6: enable ch2 in the middle of a ch0 period
    send(0, 8, 4, 1'b1);
    step(); step(); step();
    send(2, 4, 2, 1'b1);
`ifdef CKE_PHASE_SYNC_EN
    for (int i = 0; i < 20 && !tick[2]; i++) step();
    chk("t6_tick2", longint'(tick[2]), 1);
    chk("t6_tick0_aligned", longint'(tick[0]), 1);
`else
    step();
    chk("t6_tick2", longint'(tick[2]), 1);
    chk("t6_cke2", longint'(cke[2]), 1);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_ch = 2'($urandom_range(0, NCH - 1));
        cfg_div = W'($urandom_range(0, 12));
        cfg_high = W'($urandom_range(0, 14));
        cfg_en = ($urandom_range(0, 5) != 0);
        cfg_valid = 1'b1;
      end else if (cfg_valid && $urandom_range(0, 7) == 0) begin
        cfg_valid = 1'b0;
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
